// File: rtl/sigdel_interp_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | sigdel_interp_if : PCM sample handshake and DAC word bundle                 |
// | Revision 1.0                                                                |
// +----------------------------------------------------------------------------+
interface sigdel_interp_if #(
  parameter int BITLEN = 16
);
  logic [BITLEN-1:0] s_data;
  logic              s_valid;
  logic              s_ready;
  logic              clr_underrun;
  logic [BITLEN-1:0] dac_word;
  logic              underrun;
  logic              busy;

  modport master (
    output s_data, s_valid, clr_underrun,
    input  s_ready, dac_word, underrun, busy
  );

  modport slave (
    input  s_data, s_valid, clr_underrun,
    output s_ready, dac_word, underrun, busy
  );
endinterface
`default_nettype wire

// File: rtl/sigdel_interp.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | sigdel_interp : FIFO-buffered PCM upsampler feeding the sigma-delta DAC     |
// | SIGDEL_INTERP_LINEAR_EN selects linear ramps, otherwise zero-order hold.    |
// | Revision 1.0                                                                |
// +----------------------------------------------------------------------------+
module sigdel_interp #(
  parameter int BITLEN     = 16,
  parameter int OSR_LOG2   = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  wire             clk,
  input  wire             rst,
  sigdel_interp_if.slave  bus
);
  localparam int                 C_ACC_W   = BITLEN + OSR_LOG2;
  localparam int                 C_PTR_W   = $clog2(FIFO_DEPTH);
  localparam logic [BITLEN-1:0]  C_MID     = {1'b1, {(BITLEN-1){1'b0}}};
  localparam logic [C_ACC_W-1:0] C_ACC_MID = {C_MID, {OSR_LOG2{1'b0}}};
  localparam logic [C_PTR_W:0]   C_FULL    = (C_PTR_W+1)'(FIFO_DEPTH);
  localparam logic [C_PTR_W:0]   C_CNT_ONE = (C_PTR_W+1)'(1);
  localparam logic [C_PTR_W-1:0] C_PTR_ONE = C_PTR_W'(1);
  localparam logic [OSR_LOG2-1:0] C_PH_ONE = OSR_LOG2'(1);

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_RUN = 1'b1} state_t;

  logic [BITLEN-1:0]   fifo_mem_q [FIFO_DEPTH];
  logic [C_PTR_W-1:0]  wptr_q, rptr_q;
  logic [C_PTR_W:0]    count_q;
  logic                rdy_en_q;
  logic                w_push, w_pop, w_empty;
  logic [BITLEN-1:0]   w_head;

  state_t              state_q, state_d;
  logic [C_ACC_W-1:0]  acc_q, acc_d;
  logic [OSR_LOG2-1:0] phase_q, phase_d;
  logic                underrun_q, underrun_d;
  logic [BITLEN-1:0]   dac_q;

`ifdef SIGDEL_INTERP_LINEAR_EN
  logic [BITLEN-1:0]   curr_q, curr_d;
  logic signed [BITLEN:0] step_q, step_d;
  logic [C_ACC_W-1:0]  w_step_ext, w_acc_sum;
  logic [BITLEN-1:0]   w_seg_end;

  assign w_step_ext = C_ACC_W'(step_q);
  assign w_acc_sum  = acc_q + w_step_ext;
  // Last step of a segment lands exactly on the target sample.
  assign w_seg_end  = w_acc_sum[C_ACC_W-1:OSR_LOG2];
`endif

  assign bus.s_ready  = rdy_en_q && (count_q != C_FULL);
  assign w_push       = bus.s_valid && bus.s_ready;
  assign w_empty      = (count_q == '0);
  assign w_head       = fifo_mem_q[rptr_q];
  assign bus.dac_word = dac_q;
  assign bus.underrun = underrun_q;
  assign bus.busy     = (state_q == ST_RUN);

  always_ff @(posedge clk) begin
    if (w_push) begin
      fifo_mem_q[wptr_q] <= bus.s_data;
    end
  end

  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    phase_d    = phase_q;
    underrun_d = underrun_q;
    w_pop      = 1'b0;
`ifdef SIGDEL_INTERP_LINEAR_EN
    curr_d     = curr_q;
    step_d     = step_q;
`endif
    case (state_q)
      ST_IDLE: begin
        acc_d   = C_ACC_MID;
        phase_d = '0;
`ifdef SIGDEL_INTERP_LINEAR_EN
        curr_d  = C_MID;
`endif
        if (!w_empty) begin
          w_pop   = 1'b1;
          state_d = ST_RUN;
`ifdef SIGDEL_INTERP_LINEAR_EN
          step_d  = {1'b0, w_head} - {1'b0, curr_q};
`else
          acc_d   = {w_head, {OSR_LOG2{1'b0}}};
`endif
        end
      end
      default: begin
        phase_d = phase_q + C_PH_ONE;
`ifdef SIGDEL_INTERP_LINEAR_EN
        acc_d   = w_acc_sum;
`endif
        if (phase_q == '1) begin
`ifdef SIGDEL_INTERP_LINEAR_EN
          curr_d = w_seg_end;
          step_d = '0;
`endif
          if (!w_empty) begin
            w_pop  = 1'b1;
`ifdef SIGDEL_INTERP_LINEAR_EN
            step_d = {1'b0, w_head} - {1'b0, w_seg_end};
`else
            acc_d  = {w_head, {OSR_LOG2{1'b0}}};
`endif
          end else begin
            underrun_d = 1'b1;
          end
        end
      end
    endcase
    if (bus.clr_underrun) begin
      underrun_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      acc_q      <= C_ACC_MID;
      phase_q    <= '0;
      underrun_q <= 1'b0;
      dac_q      <= C_MID;
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
      rdy_en_q   <= 1'b0;
`ifdef SIGDEL_INTERP_LINEAR_EN
      curr_q     <= C_MID;
      step_q     <= '0;
`endif
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      phase_q    <= phase_d;
      underrun_q <= underrun_d;
      dac_q      <= acc_q[C_ACC_W-1:OSR_LOG2];
      rdy_en_q   <= 1'b1;
`ifdef SIGDEL_INTERP_LINEAR_EN
      curr_q     <= curr_d;
      step_q     <= step_d;
`endif
      if (w_push) begin
        wptr_q <= wptr_q + C_PTR_ONE;
      end
      if (w_pop) begin
        rptr_q <= rptr_q + C_PTR_ONE;
      end
      if (w_push && !w_pop) begin
        count_q <= count_q + C_CNT_ONE;
      end else if (w_pop && !w_push) begin
        count_q <= count_q - C_CNT_ONE;
      end
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_sigdel_interp.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_sigdel_interp : directed vectors plus randomized run against a model     |
// | Revision 1.0                                                                |
// +----------------------------------------------------------------------------+
module tb_sigdel_interp;
  localparam int BITLEN = 16, OSR_LOG2 = 2, FIFO_DEPTH = 4;
  localparam int OSR = 1 << OSR_LOG2;
  localparam int MID = 32768;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  sigdel_interp_if #(.BITLEN(BITLEN)) bus();
  sigdel_interp #(.BITLEN(BITLEN), .OSR_LOG2(OSR_LOG2), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic int pick(input int lin, input int zoh);
`ifdef SIGDEL_INTERP_LINEAR_EN
    return lin;
`else
    return zoh;
`endif
  endfunction

  // Reference: output level is the straight line between segment endpoints.
  int mq[$];
  bit m_run = 0, m_rdy = 0, m_und = 0, m_valid = 0, m_push;
  int m_start = MID, m_target = MID, m_k = 0, m_dac = MID, m_lvl;

  function automatic int m_level();
    if (!m_run) return MID;
`ifdef SIGDEL_INTERP_LINEAR_EN
    return (m_start * OSR + m_k * (m_target - m_start)) / OSR;
`else
    return m_target;
`endif
  endfunction

  always @(posedge clk) begin
    if (!rst) begin
      mq.delete();
      m_run = 0; m_rdy = 0; m_und = 0; m_dac = MID;
      m_start = MID; m_target = MID; m_k = 0;
    end else begin
      m_push = bus.s_valid && m_rdy && (mq.size() < FIFO_DEPTH);
      m_lvl  = m_level();
      if (!m_run) begin
        if (mq.size() > 0) begin
          m_start = MID; m_target = mq.pop_front(); m_k = 0; m_run = 1;
        end
      end else if (m_k == OSR - 1) begin
        m_start = m_target; m_k = 0;
        if (mq.size() > 0) m_target = mq.pop_front();
        else m_und = 1;
      end else begin
        m_k++;
      end
      if (bus.clr_underrun) m_und = 0;
      if (m_push) mq.push_back(int'(bus.s_data));
      m_rdy = 1;
      m_dac = m_lvl;
    end
    m_valid = 1;
  end

  always @(negedge clk) begin
    if (m_valid) begin
      chk("model dac_word", bus.dac_word, m_dac);
      chk("model s_ready", bus.s_ready, (m_rdy && mq.size() < FIFO_DEPTH));
      chk("model busy", bus.busy, m_run);
      chk("model underrun", bus.underrun, m_und);
    end
  end

  // Order tracker for the backpressure sequence.
  logic [15:0] bp_smp [6];
  int  bp_nxt = 0;
  bit  bp_en = 0;
  always @(negedge clk) begin
    if (bp_en && bp_nxt < 6 && bus.dac_word == bp_smp[bp_nxt]) bp_nxt++;
  end

  typedef struct {
    bit rst; bit v; logic [15:0] d; bit clr;
    logic [15:0] dac; bit rdy; bit busy; bit und;
  } vec_t;
  vec_t tbl[$];

  task automatic addv(input bit r, input bit v, input logic [15:0] d, input bit c,
                      input int dac, input bit rdy, input bit busy, input bit und);
    vec_t e;
    e.rst = r; e.v = v; e.d = d; e.clr = c;
    e.dac = 16'(dac); e.rdy = rdy; e.busy = busy; e.und = und;
    tbl.push_back(e);
  endtask

  task automatic cyc(input bit v, input logic [15:0] d, input bit c);
    bus.s_valid = v; bus.s_data = d; bus.clr_underrun = c;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b0; cyc(0, 0, 0); cyc(0, 0, 0);
    rst = 1'b1; cyc(0, 0, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [15:0] b2b_exp [5];
    bit saw_full;
    int idx;
    bus.s_valid = 0; bus.s_data = 0; bus.clr_underrun = 0;

    addv(0,0,16'h0000,0, 'h8000,0,0,0);
    addv(0,0,16'h0000,0, 'h8000,0,0,0);
    addv(1,0,16'h0000,0, 'h8000,1,0,0);
    addv(1,1,16'h8400,0, 'h8000,1,0,0);
    addv(1,0,16'h0000,0, 'h8000,1,1,0);
    addv(1,0,16'h0000,0, pick('h8000,'h8400),1,1,0);
    addv(1,0,16'h0000,0, pick('h8100,'h8400),1,1,0);
    addv(1,0,16'h0000,0, pick('h8200,'h8400),1,1,0);
    addv(1,0,16'h0000,0, pick('h8300,'h8400),1,1,1);
    addv(1,0,16'h0000,0, 'h8400,1,1,1);
    addv(1,0,16'h0000,0, 'h8400,1,1,1);
    addv(1,0,16'h0000,1, 'h8400,1,1,0);
    addv(1,0,16'h0000,1, 'h8400,1,1,0);
    addv(1,0,16'h0000,0, 'h8400,1,1,0);
    addv(1,0,16'h0000,0, 'h8400,1,1,0);
    addv(1,0,16'h0000,0, 'h8400,1,1,0);
    addv(1,0,16'h0000,0, 'h8400,1,1,1);
    for (int i = 0; i < tbl.size(); i++) begin
      rst = tbl[i].rst;
      cyc(tbl[i].v, tbl[i].d, tbl[i].clr);
      chk($sformatf("vec%0d dac_word", i), bus.dac_word, tbl[i].dac);
      chk($sformatf("vec%0d s_ready", i), bus.s_ready, tbl[i].rdy);
      chk($sformatf("vec%0d busy", i), bus.busy, tbl[i].busy);
      chk($sformatf("vec%0d underrun", i), bus.underrun, tbl[i].und);
    end

    // Full-scale swing, back-to-back pushes.
    do_reset();
    cyc(1, 16'hFFFF, 0);
    cyc(1, 16'h0000, 0);
    repeat (4) cyc(0, 0, 0);
    b2b_exp[0] = 16'(pick('hFFFF, 0)); b2b_exp[1] = 16'(pick('hBFFF, 0));
    b2b_exp[2] = 16'(pick('h7FFF, 0)); b2b_exp[3] = 16'(pick('h3FFF, 0));
    b2b_exp[4] = 16'h0000;
    for (int i = 0; i < 5; i++) begin
      cyc(0, 0, 0);
      chk($sformatf("b2b dac_word[%0d]", i), bus.dac_word, b2b_exp[i]);
    end

    // Backpressure: six samples offered continuously.
    do_reset();
    bp_smp[0] = 16'h1000; bp_smp[1] = 16'h2000; bp_smp[2] = 16'h3000;
    bp_smp[3] = 16'h4000; bp_smp[4] = 16'h5000; bp_smp[5] = 16'h6000;
    bp_nxt = 0; bp_en = 1; saw_full = 0; idx = 0;
    for (int t = 0; t < 100 && idx < 6; t++) begin
      bit r;
      r = bus.s_ready;
      if (!r) saw_full = 1;
      cyc(1, bp_smp[idx], 0);
      if (r) idx++;
    end
    chk("bp ready dropped", saw_full, 1);
    chk("bp all accepted", idx, 6);
    repeat (40) cyc(0, 0, 0);
    bp_en = 0;
    chk("bp samples in order", bp_nxt, 6);
    chk("bp final hold", bus.dac_word, 16'h6000);

    // Reset in the middle of a ramp with a sample still queued.
    do_reset();
    cyc(1, 16'h9000, 0);
    repeat (8) cyc(0, 0, 0);
    chk("mid pre-reset underrun", bus.underrun, 1);
    cyc(1, 16'h1000, 0);
    repeat (4) cyc(0, 0, 0);
    cyc(1, 16'h2000, 0);
    rst = 1'b0;
    cyc(0, 0, 0);
    chk("mid reset dac_word", bus.dac_word, 16'h8000);
    chk("mid reset underrun", bus.underrun, 0);
    chk("mid reset busy", bus.busy, 0);
    chk("mid reset s_ready", bus.s_ready, 0);
    rst = 1'b1;
    cyc(0, 0, 0);
    chk("mid release s_ready", bus.s_ready, 1);
    repeat (3) cyc(0, 0, 0);
    chk("mid flushed busy", bus.busy, 0);
    cyc(1, 16'h8400, 0);
    cyc(0, 0, 0);
    cyc(0, 0, 0);
    chk("mid restart start", bus.dac_word, pick('h8000, 'h8400));
    repeat (4) cyc(0, 0, 0);
    chk("mid restart end", bus.dac_word, 16'h8400);

    // Randomized traffic with alternating input rates.
    for (int t = 0; t < 3000; t++) begin
      bit hi_rate;
      hi_rate = ((t / 200) % 2) == 1;
      rst = ($urandom_range(0, 399) != 0);
      cyc(hi_rate ? ($urandom_range(0, 1) == 0) : ($urandom_range(0, 5) == 0),
          16'($urandom), ($urandom_range(0, 49) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/sigdel_interp.md
# sigdel_interp

Upsampling front end for the first-order sigma-delta DAC. It accepts unsigned PCM samples at a low rate over a valid/ready handshake and buffers them in a small FIFO. Each sample is stretched over 2**OSR_LOG2 modulator clocks by linear interpolation, and the result drives the DAC's BITLEN-bit unsigned input word every cycle. Output idles at midscale (analog zero) and holds the last sample on underrun.

## Interface
- BITLEN, 16, sample and DAC word width (unsigned, midscale = 2**(BITLEN-1))
- OSR_LOG2, 8, log2 of interpolation factor; OSR = 2**OSR_LOG2 cycles per sample
- FIFO_DEPTH, 4, input FIFO entries (power of two, >= 2)

- clk  input  1  modulator clock; single clock domain
- rst  input  1  synchronous, active-low reset (asserted when 0, sampled on posedge clk)
- s_data  input  BITLEN  PCM sample, unsigned
- s_valid  input  1  s_data valid
- s_ready  output  1  FIFO can accept; transfer when s_valid && s_ready
- clr_underrun  input  1  clears underrun flag
- dac_word  output  BITLEN  registered word to the sigma-delta DAC input
- underrun  output  1  sticky: sample boundary reached with FIFO empty while RUN
- busy  output  1  state == RUN

## Operation
- FIFO: FIFO_DEPTH entries, registered count; s_ready = (count != FIFO_DEPTH). Push and pop in the same cycle keep count unchanged. Pop when empty never happens.
- Registers: curr (BITLEN), step (signed BITLEN+1), acc (BITLEN+OSR_LOG2, unsigned), phase (OSR_LOG2).
- dac_word = acc[BITLEN+OSR_LOG2-1:OSR_LOG2].
- States:
  - IDLE: acc = midscale<<OSR_LOG2, curr = midscale. If the FIFO is non-empty, pop sample x, set step = x - curr, phase = 0, and go to RUN.
  - RUN: each cycle acc += step, phase += 1. When phase == OSR-1 (last cycle of the segment):
    - FIFO non-empty: pop y. Next cycle acc = x<<OSR_LOG2 (the value acc+step yields, by construction), curr = x, step = y - x, phase = 0.
    - FIFO empty: curr = x, step = 0, set underrun. Stay in RUN holding x.
- Arithmetic: step is the signed BITLEN+1-bit difference. acc is always within [0, (2**BITLEN-1)<<OSR_LOG2], so there is no overflow and no saturation logic. The truncating shift gives floor.
- Underrun: sticky. Cleared by clr_underrun (clear wins over a same-cycle set) or by reset. Output holds the last sample; it never returns to midscale without reset.
- Reset mid-operation: FIFO flushed, state IDLE, output midscale on the next edge. Any in-flight sample is discarded.

## Timing
- Reset values: dac_word = 2**(BITLEN-1), s_ready = 0 while rst = 0 and 1 from the first cycle after release, underrun = 0, busy = 0.
- Sample pushed at edge N into an empty FIFO in IDLE: popped at N+1; RUN with dac_word = midscale at N+2; dac_word = sample at N+2+OSR.
- In steady state, one sample is popped every OSR cycles. Sustained input rate must be ≤ 1/OSR, otherwise s_ready deasserts (backpressure, no loss).
- Segment boundary with an empty FIFO followed by a late push: the sample is popped at the next phase == OSR-1 boundary, so latency is up to OSR extra cycles. Phase stays aligned.

## Configuration
- SIGDEL_INTERP_LINEAR_EN defined: linear interpolation as above.
- Not defined: zero-order hold. step logic is removed; at each segment start acc = new sample<<OSR_LOG2 and stays constant. dac_word steps to the sample value at the same cycle the linear ramp would begin (N+2 in the example above). Handshake, FIFO, underrun, and reset behaviour are identical.

## Test plan
(OSR_LOG2 = 2, BITLEN = 16)
- Reset release, no input: dac_word = 0x8000, busy = 0, s_ready = 1 one cycle after rst goes high.
- Push 0x8400 (linear): dac_word 0x8000, 0x8100, 0x8200, 0x8300, 0x8400 on consecutive cycles starting N+2. Then hold 0x8400 with underrun = 1.
- Push 0xFFFF then 0x0000 back-to-back: second segment reads 0xFFFF, 0xBFFF, 0x7FFF, 0x3FFF, 0x0000. No wrap.
- Hold s_valid high with 6 samples: s_ready drops after the FIFO reaches 4 entries. All 6 samples appear in order at 4-cycle segment boundaries with no loss.
- rst = 0 mid-ramp: next cycle dac_word = 0x8000, FIFO empty, underrun = 0. A subsequent push restarts from midscale.
- Macro undefined, push 0x8400: dac_word jumps to 0x8400 at N+2 and holds.
